// File: rtl/math_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// math_pkg : reduction operator selectors shared by the math blocks
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
package math_pkg;
  localparam int MATH_OP_XOR = 0;
  localparam int MATH_OP_ADD = 1;
endpackage
`default_nettype wire

// File: rtl/math_op_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// math_op_arb : round-robin packet scheduler sharing one XOR/ADD reduction
// Rev 1.0     : initial release
// ---------------------------------------------------------------------------
module math_op_arb #(
  parameter int REQ_COUNT = 4,
  parameter int MATH_OP   = math_pkg::MATH_OP_XOR,
  parameter int I_COUNT   = 8,
  parameter int I_WIDTH   = 4,
  parameter int O_WIDTH   = 8,
  localparam int IDW      = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [REQ_COUNT-1:0][I_COUNT-1:0][I_WIDTH-1:0] req_data_i,
  input  logic [REQ_COUNT-1:0]                        req_valid_i,
  input  logic [REQ_COUNT-1:0]                        req_last_i,
  output logic [REQ_COUNT-1:0]                        req_ready_o,
  output logic [O_WIDTH-1:0]                          out_data_o,
  output logic [IDW-1:0]                              out_id_o,
  output logic                                        out_valid_o,
  input  logic                                        out_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [IDW-1:0]       r_ptr;
  logic [IDW-1:0]       r_grant;
  logic [O_WIDTH-1:0]   r_acc;

  logic                 w_any;
  logic [IDW-1:0]       w_pick;
  logic [O_WIDTH-1:0]   w_red;
  logic [O_WIDTH-1:0]   w_acc_next;
  logic                 w_accept;

  // Descending scan so the last hit is the nearest valid requester at/after r_ptr.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = REQ_COUNT - 1; k >= 0; k--) begin
      logic [IDW-1:0] v_idx;
      v_idx = IDW'((int'(r_ptr) + k) % REQ_COUNT);
      if (req_valid_i[v_idx]) begin
        w_any  = 1'b1;
        w_pick = v_idx;
      end
    end
  end

  if (MATH_OP == math_pkg::MATH_OP_ADD) begin : g_add
    always_comb begin
      w_red = '0;
      for (int e = 0; e < I_COUNT; e++) begin
        w_red = w_red + O_WIDTH'(req_data_i[r_grant][e]);
      end
    end
    assign w_acc_next = r_acc + w_red;
  end else begin : g_xor
    always_comb begin
      w_red = '0;
      for (int e = 0; e < I_COUNT; e++) begin
        w_red = w_red ^ O_WIDTH'(req_data_i[r_grant][e]);
      end
    end
    assign w_acc_next = r_acc ^ w_red;
  end

  assign w_accept = (r_state == S_BUSY) && req_valid_i[r_grant];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_acc       <= '0;
      req_ready_o <= '0;
      out_data_o  <= '0;
      out_id_o    <= '0;
      out_valid_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant     <= w_pick;
            r_acc       <= '0;
            req_ready_o <= REQ_COUNT'(1) << w_pick;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            if (req_last_i[r_grant]) begin
              out_data_o  <= w_acc_next;
              out_id_o    <= r_grant;
              out_valid_o <= 1'b1;
              req_ready_o <= '0;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            r_ptr       <= (r_grant == IDW'(REQ_COUNT - 1)) ? '0 : r_grant + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          req_ready_o <= '0;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_math_op_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_math_op_arb : XOR and ADD instances on shared stimulus vs packet model
// Rev 1.0        : initial release
// ---------------------------------------------------------------------------
module tb_math_op_arb;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [3:0][7:0][3:0]   req_data;
  logic [3:0]             req_valid;
  logic [3:0]             req_last;
  logic                   out_ready;

  logic [3:0] rdy_x, rdy_a;
  logic [7:0] dx, da;
  logic [1:0] id_x, id_a;
  logic       ov_x, ov_a;

  int total = 0;
  int bad   = 0;

  int m_ptr;
  int m_grant;
  int m_x [4];
  int m_s [4];

  always #5 clk = ~clk;

  math_op_arb #(.MATH_OP(math_pkg::MATH_OP_XOR)) u_xor (
    .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .req_valid_i(req_valid),
    .req_last_i(req_last), .req_ready_o(rdy_x), .out_data_o(dx), .out_id_o(id_x),
    .out_valid_o(ov_x), .out_ready_i(out_ready)
  );

  math_op_arb #(.MATH_OP(math_pkg::MATH_OP_ADD)) u_add (
    .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .req_valid_i(req_valid),
    .req_last_i(req_last), .req_ready_o(rdy_a), .out_data_o(da), .out_id_o(id_a),
    .out_valid_o(ov_a), .out_ready_i(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and check every observable rule against the packet model.
  task automatic tick();
    logic [3:0]           p_v, p_l, p_rdy, e_rdy;
    logic                 p_ov, p_or, p_rst, last_hs, e_ov;
    logic [7:0]           p_dx, p_da;
    logic [1:0]           p_id;
    logic [3:0][7:0][3:0] p_d;
    int                   first;
    p_v = req_valid; p_l = req_last; p_rdy = rdy_x; p_ov = ov_x; p_or = out_ready;
    p_rst = rst; p_dx = dx; p_da = da; p_id = id_x; p_d = req_data;
    @(posedge clk);
    #1;
    if (p_rst) begin
      chk("rst_ready", {rdy_x, rdy_a}, 0);
      chk("rst_valid", {ov_x, ov_a}, 0);
      chk("rst_data",  {dx, da}, 0);
      chk("rst_id",    {id_x, id_a}, 0);
      m_ptr = 0;
      return;
    end
    last_hs = 1'b0;
    for (int r = 0; r < 4; r++) begin
      if (p_v[r] && p_rdy[r]) begin
        for (int e = 0; e < 8; e++) begin
          m_x[r] = m_x[r] ^ int'(p_d[r][e]);
          m_s[r] = m_s[r] + int'(p_d[r][e]);
        end
        if (p_l[r]) last_hs = 1'b1;
      end
    end
    e_rdy = 4'b0;
    if (p_ov) begin
      e_rdy = 4'b0;
    end else if (p_rdy != 4'b0) begin
      e_rdy = last_hs ? 4'b0 : p_rdy;
    end else if (p_v != 4'b0) begin
      first = 0;
      for (int k = 3; k >= 0; k--)
        if (p_v[(m_ptr + k) % 4]) first = (m_ptr + k) % 4;
      e_rdy      = 4'b1 << first;
      m_grant    = first;
      m_x[first] = 0;
      m_s[first] = 0;
    end
    chk("ready_xor", rdy_x, e_rdy);
    chk("ready_add", rdy_a, e_rdy);
    e_ov = (p_ov && !p_or) || last_hs;
    chk("ovalid_xor", ov_x, e_ov);
    chk("ovalid_add", ov_a, e_ov);
    if (ov_x && !p_ov) begin
      chk("res_id_xor", id_x, m_grant);
      chk("res_id_add", id_a, m_grant);
      chk("res_xor", dx, m_x[m_grant] & 8'hFF);
      chk("res_add", da, m_s[m_grant] % 256);
    end
    if (p_ov) begin
      chk("hold_xor", dx, p_dx);
      chk("hold_add", da, p_da);
      chk("hold_id",  id_x, p_id);
      if (p_or) m_ptr = (int'(p_id) + 1) % 4;
    end
  endtask

  task automatic set_beat(input int r, input logic [3:0] e0, input logic [3:0] rest);
    for (int e = 0; e < 8; e++) req_data[r][e] = (e == 0) ? e0 : rest;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] seq [6];
    logic [7:0] exp_x;
    int         nseq;
    rst = 1'b1; req_valid = 4'h0; req_last = 4'h0; req_data = '0; out_ready = 1'b0;
    m_ptr = 0; m_grant = 0;
    for (int r = 0; r < 4; r++) begin m_x[r] = 0; m_s[r] = 0; end

    // Reset with every requester asserting valid
    req_valid = 4'hF;
    do_reset(2);
    req_valid = 4'h0;

    // XOR single beat from requester 1
    set_beat(1, 4'h5, 4'h3);
    req_valid = 4'b0010; req_last = 4'b0010; out_ready = 1'b1;
    tick();
    chk("t2_ready", rdy_x, 4'b0010);
    tick();
    chk("t2_ov",   ov_x, 1);
    chk("t2_xor",  dx, 8'h06);
    chk("t2_add",  da, 8'h1A);
    chk("t2_id",   id_x, 1);
    req_valid = 4'h0; req_last = 4'h0;
    tick();
    chk("t2_ov_drop", ov_x, 0);

    // ADD three-beat packet from requester 2
    set_beat(2, 4'hF, 4'hF);
    req_valid = 4'b0100;
    tick(); tick(); tick();
    req_last = 4'b0100;
    tick();
    chk("t3_add", da, 8'h68);
    chk("t3_xor", dx, 8'h00);
    chk("t3_id",  id_a, 2);
    req_valid = 4'h0; req_last = 4'h0;
    tick();

    // Round robin with all requesters busy and single-beat packets
    do_reset(1);
    for (int i = 0; i < 6; i++) seq[i] = 2'bxx;
    nseq = 0;
    req_valid = 4'hF; req_last = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      logic was;
      was = ov_x;
      tick();
      if (ov_x && !was && nseq < 6) begin seq[nseq] = id_x; nseq++; end
    end
    for (int i = 0; i < 6; i++) chk("t4_rr_order", seq[i], i % 4);
    req_valid = 4'h0; req_last = 4'h0;
    tick(); tick();

    // Stall on the granted requester, then consumer backpressure
    do_reset(1);
    out_ready = 1'b0;
    set_beat(0, 4'h9, 4'h1);
    set_beat(3, 4'h7, 4'h7);
    req_valid = 4'b1001;
    tick();
    tick();
    req_valid = 4'b1000;
    repeat (3) begin tick(); chk("t5_r3_wait", rdy_x[3], 0); end
    set_beat(0, 4'hC, 4'h2);
    req_valid = 4'b1001; req_last = 4'b0001;
    tick();
    exp_x = 8'h09 ^ 8'h01 ^ 8'h0C ^ 8'h02;
    chk("t5_xor", dx, exp_x);
    req_valid = 4'b0000; req_last = 4'b0000;
    repeat (4) begin tick(); chk("t5_stall_ov", ov_x, 1); chk("t5_stall_data", dx, exp_x); end
    out_ready = 1'b1;
    tick();
    chk("t5_release", ov_x, 0);
    chk("t5_keep_id", id_x, 0);

    // Reset partway through a packet
    set_beat(0, 4'h4, 4'h4);
    req_valid = 4'b0001;
    tick(); tick(); tick();
    do_reset(1);
    req_valid = 4'b0000;
    chk("t6_no_ov", ov_x, 0);
    set_beat(2, 4'h1, 4'h1);
    req_valid = 4'b0100; req_last = 4'b0100;
    tick();
    tick();
    chk("t6_xor", dx, 8'h00);
    chk("t6_id",  id_x, 2);
    req_valid = 4'h0; req_last = 4'h0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = 4'($urandom) & 4'($urandom | $urandom);
      req_last  = 4'($urandom) & 4'($urandom);
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
